// File: rtl/wb_pkg.sv
// ---------------------------------------------------------------------------
// wb_pkg
// Shared definitions for the Wishbone secondary RAM:
//   - bus width constants (data width, byte-select width)
//   - transfer FSM state encoding
//   - address range check used when a request is latched
// ---------------------------------------------------------------------------
package wb_pkg;

   localparam int WB_DATA_W = 32;
   localparam int WB_SEL_W  = 4;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WAIT = 2'd1,
      ST_RESP = 2'd2
   } wb_state_t;

   // True when adr lies in [base, base + span). The offset is formed in 33
   // bits so an address below base borrows into bit 32 and fails the compare
   // instead of wrapping around to a small offset.
   function automatic logic wb_addr_in_range(input logic [31:0] adr,
                                             input logic [31:0] base,
                                             input logic [32:0] span);
      logic [32:0] off;
      off = {1'b0, adr} - {1'b0, base};
      return (off < span);
   endfunction

endpackage

// File: rtl/wb_sec_mem.sv
// ---------------------------------------------------------------------------
// wb_sec_mem
// Single-port synchronous RAM, DEPTH_WORDS x 32, with per-byte write enables.
// Read data is registered: o_rdata reflects the word addressed at the
// previous rising edge (read-before-write on a simultaneous write).
// Ports:
//   i_clk    clock
//   i_addr   word address
//   i_we     write enable (qualified per lane by i_be)
//   i_be     byte-lane enables, bit n covers bits 8n+7:8n
//   i_wdata  write data
//   o_rdata  registered read data
// Contents are not reset.
// ---------------------------------------------------------------------------
module wb_sec_mem
   import wb_pkg::*;
#(
   parameter int DEPTH_WORDS = 1024
) (
   input  logic                          i_clk,
   input  logic [$clog2(DEPTH_WORDS)-1:0] i_addr,
   input  logic                          i_we,
   input  logic [WB_SEL_W-1:0]           i_be,
   input  logic [WB_DATA_W-1:0]          i_wdata,
   output logic [WB_DATA_W-1:0]          o_rdata
);

   logic [WB_DATA_W-1:0] r_mem [DEPTH_WORDS];
   logic [WB_DATA_W-1:0] r_rdata;

   always_ff @(posedge i_clk) begin
      for (int n = 0; n < WB_SEL_W; n++) begin
         if (i_we && i_be[n]) begin
            r_mem[i_addr][8*n +: 8] <= i_wdata[8*n +: 8];
         end
      end
      r_rdata <= r_mem[i_addr];
   end

   assign o_rdata = r_rdata;

endmodule

// File: rtl/wb_secondary_ram.sv
// ---------------------------------------------------------------------------
// wb_secondary_ram
// Wishbone (classic) secondary backed by a byte-enabled RAM. A request is
// latched in IDLE, held for WAIT_STATES cycles in WAIT, and terminated with a
// one-cycle ack (or err for a bad address / empty select) in RESP.
// Ports:
//   wb_clk_i  bus clock          wb_rst_i  synchronous active-high reset
//   wb_cyc_i  cycle in progress  wb_stb_i  strobe / select
//   wb_we_i   1 = write          wb_adr_i  byte address
//   wb_dat_i  write data         wb_sel_i  byte lane enables
//   wb_dat_o  read data (0 unless acking a read)
//   wb_ack_o  normal termination wb_err_o  error termination
// ---------------------------------------------------------------------------
module wb_secondary_ram
   import wb_pkg::*;
#(
   parameter int          DEPTH_WORDS = 1024,
   parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
   parameter int          WAIT_STATES = 1
) (
   input  logic                 wb_clk_i,
   input  logic                 wb_rst_i,
   input  logic                 wb_cyc_i,
   input  logic                 wb_stb_i,
   input  logic                 wb_we_i,
   input  logic [31:0]          wb_adr_i,
   input  logic [WB_DATA_W-1:0] wb_dat_i,
   input  logic [WB_SEL_W-1:0]  wb_sel_i,
   output logic [WB_DATA_W-1:0] wb_dat_o,
   output logic                 wb_ack_o,
   output logic                 wb_err_o
);

   localparam int          AW   = $clog2(DEPTH_WORDS);
   localparam logic [32:0] SPAN = 33'(DEPTH_WORDS) << 2;

   wb_state_t            r_state, w_state_nxt;
   logic [2:0]           r_cnt, w_cnt_nxt;
   logic [AW-1:0]        r_idx;
   logic                 r_we;
   logic                 r_errc;
   logic [WB_DATA_W-1:0] r_dat;
   logic [WB_SEL_W-1:0]  r_sel;
   logic                 r_ack, r_err;

   logic                 w_req;
   logic                 w_latch;
   logic                 w_err_in;
   logic                 w_err_now;
   logic [AW-1:0]        w_idx_in;
   logic [AW-1:0]        w_mem_idx;
   logic                 w_mem_we;
   logic [WB_DATA_W-1:0] w_rdata;

   assign w_req    = wb_cyc_i & wb_stb_i;
   assign w_idx_in = AW'((wb_adr_i - BASE_ADDR) >> 2);
   assign w_err_in = !wb_addr_in_range(wb_adr_i, BASE_ADDR, SPAN)
                   || (wb_adr_i[1:0] != 2'b00)
                   || (wb_sel_i == '0);

   // In IDLE the RAM is addressed straight from the bus so that a zero-wait
   // read has its data registered by the time RESP is entered; afterwards the
   // latched index is used so mid-transfer address changes are ignored.
   assign w_mem_idx = (r_state == ST_IDLE) ? w_idx_in : r_idx;

   // The error flag for the termination being scheduled: taken from the bus
   // when entering RESP directly from IDLE, from the latch otherwise.
   assign w_err_now = w_latch ? w_err_in : r_errc;

   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_latch     = 1'b0;
      w_mem_we    = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (w_req) begin
               w_latch     = 1'b1;
               w_cnt_nxt   = 3'd0;
               w_state_nxt = (WAIT_STATES == 0) ? ST_RESP : ST_WAIT;
            end
         end
         ST_WAIT: begin
            if (!w_req) begin
               w_state_nxt = ST_IDLE;
            end else if (r_cnt == 3'(WAIT_STATES - 1)) begin
               w_state_nxt = ST_RESP;
            end else begin
               w_cnt_nxt = r_cnt + 3'd1;
            end
         end
         ST_RESP: begin
            // Always one cycle; a request still held here is picked up again
            // from IDLE, never re-terminated. The write commits at the edge
            // closing RESP unless the master has withdrawn or reset hits.
            w_state_nxt = ST_IDLE;
            w_mem_we    = w_req & r_we & ~r_errc & ~wb_rst_i;
         end
         default: begin
            w_state_nxt = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         r_state <= ST_IDLE;
         r_cnt   <= 3'd0;
         r_ack   <= 1'b0;
         r_err   <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
         r_ack   <= (w_state_nxt == ST_RESP) & ~w_err_now;
         r_err   <= (w_state_nxt == ST_RESP) &  w_err_now;
      end
   end

   // Transfer attributes; only meaningful while a transfer is in flight.
   always_ff @(posedge wb_clk_i) begin
      if (w_latch) begin
         r_idx  <= w_idx_in;
         r_we   <= wb_we_i;
         r_errc <= w_err_in;
         r_dat  <= wb_dat_i;
         r_sel  <= wb_sel_i;
      end
   end

   wb_sec_mem #(
      .DEPTH_WORDS (DEPTH_WORDS)
   ) u_mem (
      .i_clk   (wb_clk_i),
      .i_addr  (w_mem_idx),
      .i_we    (w_mem_we),
      .i_be    (r_sel),
      .i_wdata (r_dat),
      .o_rdata (w_rdata)
   );

   assign wb_ack_o = r_ack;
   assign wb_err_o = r_err;
   assign wb_dat_o = (r_ack & ~r_we) ? w_rdata : '0;

endmodule

// File: tb/tb_wb_secondary_ram.sv
// ---------------------------------------------------------------------------
// tb_wb_secondary_ram
// Directed bench for wb_secondary_ram with DEPTH_WORDS=1024, BASE_ADDR=0,
// WAIT_STATES=1. Inputs change 1 time unit after a rising edge; outputs are
// observed at the same point, i.e. they show the state after that edge.
// ---------------------------------------------------------------------------
module tb_wb_secondary_ram;

   logic        clk = 1'b0;
   logic        rst;
   logic        cyc, stb, we;
   logic [31:0] adr, dat_i;
   logic [3:0]  sel;
   logic [31:0] dat_o;
   logic        ack, err;

   int n_vec = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   wb_secondary_ram #(
      .DEPTH_WORDS (1024),
      .BASE_ADDR   (32'h0000_0000),
      .WAIT_STATES (1)
   ) dut (
      .wb_clk_i (clk),
      .wb_rst_i (rst),
      .wb_cyc_i (cyc),
      .wb_stb_i (stb),
      .wb_we_i  (we),
      .wb_adr_i (adr),
      .wb_dat_i (dat_i),
      .wb_sel_i (sel),
      .wb_dat_o (dat_o),
      .wb_ack_o (ack),
      .wb_err_o (err)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp)
      else begin
         n_bad++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // One classic-cycle transfer: strobe until a termination is seen (bounded),
   // hold strobe through the terminating edge, then release.
   task automatic xfer(input logic w, input logic [31:0] a, input logic [31:0] d,
                       input logic [3:0] s, output logic t_ack, output logic t_err,
                       output logic [31:0] t_dat, output int lat);
      we = w; adr = a; dat_i = d; sel = s; cyc = 1'b1; stb = 1'b1;
      t_ack = 1'b0; t_err = 1'b0; t_dat = '0; lat = 0;
      for (int i = 1; i <= 10; i++) begin
         tick();
         if (ack || err) begin
            t_ack = ack; t_err = err; t_dat = dat_o; lat = i;
            break;
         end
      end
      tick();
      chk("no_double_term", 32'({ack, err}), 32'd0);
      cyc = 1'b0; stb = 1'b0;
   endtask

   task automatic do_write(input string tag, input logic [31:0] a, input logic [31:0] d,
                           input logic [3:0] s, input logic exp_err);
      logic ta, te; logic [31:0] td; int lat;
      xfer(1'b1, a, d, s, ta, te, td, lat);
      chk({tag, "_lat"}, 32'(lat), 32'd2);
      chk({tag, "_ack"}, 32'(ta), 32'(!exp_err));
      chk({tag, "_err"}, 32'(te), 32'(exp_err));
      chk({tag, "_dat"}, td, 32'd0);
   endtask

   task automatic do_read(input string tag, input logic [31:0] a, input logic [3:0] s,
                          input logic [31:0] exp_dat, input logic exp_err);
      logic ta, te; logic [31:0] td; int lat;
      xfer(1'b0, a, 32'hFFFF_FFFF, s, ta, te, td, lat);
      chk({tag, "_lat"}, 32'(lat), 32'd2);
      chk({tag, "_ack"}, 32'(ta), 32'(!exp_err));
      chk({tag, "_err"}, 32'(te), 32'(exp_err));
      chk({tag, "_dat"}, td, exp_dat);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [5:0]  pat_a, pat_e;
      logic [31:0] d1, d2;

      rst = 1'b1; cyc = 1'b0; stb = 1'b0; we = 1'b0;
      adr = '0; dat_i = '0; sel = '0;
      tick(); tick(); tick();
      chk("rst_ack", 32'(ack), 32'd0);
      chk("rst_err", 32'(err), 32'd0);
      chk("rst_dat", dat_o, 32'd0);
      rst = 1'b0;
      tick();

      // Full-word write then read back
      do_write("wr10", 32'h10, 32'hDEAD_BEEF, 4'b1111, 1'b0);
      do_read ("rd10", 32'h10, 4'b1111, 32'hDEAD_BEEF, 1'b0);

      // Single-lane write merges with existing word; read ignores sel
      do_write("wr10_b0", 32'h10, 32'h0000_00AA, 4'b0001, 1'b0);
      do_read ("rd10_b0", 32'h10, 4'b0010, 32'hDEAD_BEAA, 1'b0);

      // Out-of-range, misaligned, empty-select all terminate with err
      do_read ("rd1000", 32'h1000, 4'b1111, 32'd0, 1'b1);
      do_write("wr12", 32'h12, 32'hFFFF_FFFF, 4'b1111, 1'b1);
      do_write("wr10_sel0", 32'h10, 32'h0000_0000, 4'b0000, 1'b1);
      do_read ("rd10_keep", 32'h10, 4'b1111, 32'hDEAD_BEAA, 1'b0);

      // Strobe dropped in WAIT aborts the write
      do_write("wr20_init", 32'h20, 32'h1111_1111, 4'b1111, 1'b0);
      we = 1'b1; adr = 32'h20; dat_i = 32'h1234_5678; sel = 4'b1111;
      cyc = 1'b1; stb = 1'b1;
      tick();
      stb = 1'b0;
      tick();
      chk("abort_term1", 32'({ack, err}), 32'd0);
      tick();
      chk("abort_term2", 32'({ack, err}), 32'd0);
      cyc = 1'b0;
      do_read("rd20_abort", 32'h20, 4'b1111, 32'h1111_1111, 1'b0);

      // Reset while in WAIT
      we = 1'b0; adr = 32'h10; sel = 4'b1111; cyc = 1'b1; stb = 1'b1;
      tick();
      rst = 1'b1; cyc = 1'b0; stb = 1'b0;
      tick();
      chk("rstw_ack", 32'(ack), 32'd0);
      chk("rstw_err", 32'(err), 32'd0);
      chk("rstw_dat", dat_o, 32'd0);
      rst = 1'b0;
      tick();
      chk("rstw_idle", 32'({ack, err}), 32'd0);
      do_read("rd10_after_rst", 32'h10, 4'b1111, 32'hDEAD_BEAA, 1'b0);

      // Reset on the edge closing RESP must block the write commit
      we = 1'b1; adr = 32'h20; dat_i = 32'hCAFE_F00D; sel = 4'b1111;
      cyc = 1'b1; stb = 1'b1;
      tick();
      tick();
      chk("rstr_ack_seen", 32'(ack), 32'd1);
      rst = 1'b1;
      tick();
      rst = 1'b0; cyc = 1'b0; stb = 1'b0;
      chk("rstr_ack_clr", 32'(ack), 32'd0);
      tick();
      do_read("rd20_rst", 32'h20, 4'b1111, 32'h1111_1111, 1'b0);

      // Bus inputs changed mid-transfer are ignored
      we = 1'b1; adr = 32'h30; dat_i = 32'h0BAD_F00D; sel = 4'b1111;
      cyc = 1'b1; stb = 1'b1;
      tick();
      we = 1'b0; adr = 32'h1000; dat_i = 32'h0; sel = 4'b0000;
      tick();
      chk("chg_ack", 32'(ack), 32'd1);
      chk("chg_err", 32'(err), 32'd0);
      tick();
      cyc = 1'b0; stb = 1'b0;
      do_read("rd30", 32'h30, 4'b1111, 32'h0BAD_F00D, 1'b0);

      // Back-to-back reads with strobe held throughout
      do_write("wr0", 32'h0, 32'hA5A5_A5A5, 4'b1111, 1'b0);
      do_write("wr4", 32'h4, 32'h5A5A_5A5A, 4'b1111, 1'b0);
      we = 1'b0; adr = 32'h0; sel = 4'b1111; cyc = 1'b1; stb = 1'b1;
      pat_a = '0; pat_e = '0; d1 = '0; d2 = '0;
      for (int i = 1; i <= 6; i++) begin
         tick();
         pat_a = {pat_a[4:0], ack};
         pat_e = {pat_e[4:0], err};
         if (i == 2) begin
            d1  = dat_o;
            adr = 32'h4;
         end
         if (i == 5) d2 = dat_o;
      end
      cyc = 1'b0; stb = 1'b0;
      chk("b2b_ack_pattern", 32'(pat_a), 32'(6'b010010));
      chk("b2b_err_pattern", 32'(pat_e), 32'(6'b000000));
      chk("b2b_dat0", d1, 32'hA5A5_A5A5);
      chk("b2b_dat4", d2, 32'h5A5A_5A5A);
      tick();
      chk("b2b_idle", 32'({ack, err}), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
